sad_min_tracker: RTL

Downstream result stage of the SAD processor. Consumes the stream of saturated 10-bit SAD scores produced by the PE array, one candidate position per beat. Tracks the minimum score and the index of the candidate that produced it. Presents a held, acknowledged result per search window to the host/controller.

---
 rtl/sad_min_tracker.sv | 168 ++++++++++++++++
 1 files changed

// File: rtl/sad_min_tracker.sv
// Minimum-SAD tracker: scans one search window of scores, reports min, its index, count and overflow.
// Optional macro SAD_SECOND_BEST_EN adds out_second, the runner-up score of the window.
module sad_min_tracker #(
    parameter logic [9:0] THRESHOLD = 10'd500,
    parameter int         INDEX_W   = 12
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               in_valid,
    input  logic [9:0]         in_sad,
    input  logic               in_last,
    input  logic               out_ack,
    output logic               busy,
    output logic               out_valid,
    output logic [9:0]         out_min,
    output logic [INDEX_W-1:0] out_index,
    output logic [INDEX_W-1:0] out_count,
    output logic               out_match,
    output logic               out_overflow,
`ifdef SAD_SECOND_BEST_EN
    output logic [9:0]         out_second,
`endif
    output logic [1:0]         dbg_state
);

    // Handshake: a candidate is taken on every edge where state is SCAN, in_valid is high and
    // start is low; the result is held while out_valid is high and released on the out_ack edge.
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_SCAN = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    localparam logic [INDEX_W-1:0] CNT_MAX = '1;

    logic [1:0]         state_q, state_d;
    logic [9:0]         run_min_q, run_min_d;
    logic [INDEX_W-1:0] run_idx_q, run_idx_d;
    logic [INDEX_W-1:0] run_cnt_q, run_cnt_d;
    logic               run_ovf_q, run_ovf_d;
    logic [9:0]         res_min_q, res_min_d;
    logic [INDEX_W-1:0] res_idx_q, res_idx_d;
    logic [INDEX_W-1:0] res_cnt_q, res_cnt_d;
    logic               res_ovf_q, res_ovf_d;
`ifdef SAD_SECOND_BEST_EN
    logic [9:0]         run_sec_q, run_sec_d;
    logic [9:0]         res_sec_q, res_sec_d;
`endif

    always_comb begin
        state_d   = state_q;
        run_min_d = run_min_q;
        run_idx_d = run_idx_q;
        run_cnt_d = run_cnt_q;
        run_ovf_d = run_ovf_q;
        res_min_d = res_min_q;
        res_idx_d = res_idx_q;
        res_cnt_d = res_cnt_q;
        res_ovf_d = res_ovf_q;
`ifdef SAD_SECOND_BEST_EN
        run_sec_d = run_sec_q;
        res_sec_d = res_sec_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d   = S_SCAN;
                    run_min_d = 10'h3FF;
                    run_idx_d = '0;
                    run_cnt_d = '0;
                    run_ovf_d = 1'b0;
`ifdef SAD_SECOND_BEST_EN
                    run_sec_d = 10'h3FF;
`endif
                end
            end
            S_SCAN: begin
                if (start) begin
                    run_min_d = 10'h3FF;
                    run_idx_d = '0;
                    run_cnt_d = '0;
                    run_ovf_d = 1'b0;
`ifdef SAD_SECOND_BEST_EN
                    run_sec_d = 10'h3FF;
`endif
                end else if (in_valid) begin
                    // Index is the saturated count, so a late winner past overflow records all-ones.
                    if (in_sad < run_min_q) begin
                        run_min_d = in_sad;
                        run_idx_d = run_cnt_q;
`ifdef SAD_SECOND_BEST_EN
                        run_sec_d = run_min_q;
                    end else if (in_sad < run_sec_q) begin
                        run_sec_d = in_sad;
`endif
                    end
                    if (run_cnt_q == CNT_MAX) begin
                        run_ovf_d = 1'b1;
                    end else begin
                        run_cnt_d = run_cnt_q + INDEX_W'(1);
                    end
                    if (in_last) begin
                        state_d   = S_DONE;
                        res_min_d = run_min_d;
                        res_idx_d = run_idx_d;
                        res_cnt_d = run_cnt_d;
                        res_ovf_d = run_ovf_d;
`ifdef SAD_SECOND_BEST_EN
                        res_sec_d = run_sec_d;
`endif
                    end
                end
            end
            S_DONE: begin
                if (out_ack) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            run_min_q <= 10'h3FF;
            run_idx_q <= '0;
            run_cnt_q <= '0;
            run_ovf_q <= 1'b0;
            res_min_q <= 10'h3FF;
            res_idx_q <= '0;
            res_cnt_q <= '0;
            res_ovf_q <= 1'b0;
`ifdef SAD_SECOND_BEST_EN
            run_sec_q <= 10'h3FF;
            res_sec_q <= 10'h3FF;
`endif
        end else begin
            state_q   <= state_d;
            run_min_q <= run_min_d;
            run_idx_q <= run_idx_d;
            run_cnt_q <= run_cnt_d;
            run_ovf_q <= run_ovf_d;
            res_min_q <= res_min_d;
            res_idx_q <= res_idx_d;
            res_cnt_q <= res_cnt_d;
            res_ovf_q <= res_ovf_d;
`ifdef SAD_SECOND_BEST_EN
            run_sec_q <= run_sec_d;
            res_sec_q <= res_sec_d;
`endif
        end
    end

    assign busy         = (state_q == S_SCAN);
    assign out_valid    = (state_q == S_DONE);
    assign out_min      = res_min_q;
    assign out_index    = res_idx_q;
    assign out_count    = res_cnt_q;
    assign out_overflow = res_ovf_q;
    assign out_match    = (res_min_q < THRESHOLD);
    assign dbg_state    = state_q;
`ifdef SAD_SECOND_BEST_EN
    assign out_second   = res_sec_q;
`endif

endmodule
